// File: rtl/rf_2p_port_arb_pkg.sv
// Shared configuration for the two-port register-file arbiter.
// It holds the read latency of the RF macro and the requester index type.
package RFCfg;

   localparam int RF_RD_LAT   = 1;
   localparam int RF_NREQ_MAX = 8;

   // Sized for the largest supported requester count, so every NREQ setting fits.
   typedef logic [$clog2(RF_NREQ_MAX)-1:0] rf_req_idx_t;

endpackage

// File: rtl/rf_2p_port_arb_rr_arb.sv
// Round-robin arbiter. The winner is the first request at or after the pointer.
// The pointer advances past the winner on every accepted grant.
module rr_arb #(
   parameter int NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic                    en,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] k;
   logic          found;
   int            kk;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      kk    = 0;
      k     = '0;
      for (int i = 0; i < NREQ; i++) begin
         kk = int'(ptr) + i;
         if (kk >= NREQ) kk = kk - NREQ;
         k = PW'(kk);
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/rf_2p_port_arb.sv
// Shares one 1R1W register file among NREQ requesters using independent
// round-robin read and write arbiters. Read data is returned one cycle later.
module rf_2p_port_arb
   import RFCfg::*;
#(
   parameter int NREQ   = 4,
   parameter int WORDWD = 12,
   parameter int DWD    = 16,
   parameter int AWD    = $clog2(WORDWD),
   parameter int SIZE   = 1
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic [NREQ-1:0]                       i_rreq,
   input  logic [NREQ-1:0][AWD-1:0]              i_raddr,
   output logic [NREQ-1:0]                       o_rgnt,
   output logic [NREQ-1:0]                       o_rvalid,
   output logic [SIZE-1:0][DWD-1:0]              o_rdata,
   input  logic [NREQ-1:0]                       i_wreq,
   input  logic [NREQ-1:0][AWD-1:0]              i_waddr,
   input  logic [NREQ-1:0][SIZE-1:0][DWD-1:0]    i_wdata,
   output logic [NREQ-1:0]                       o_wgnt,
   output logic                                  o_read,
   output logic [AWD-1:0]                        o_raddr,
   output logic                                  o_write,
   output logic [AWD-1:0]                        o_waddr,
   output logic [SIZE-1:0][DWD-1:0]              o_wdata,
   input  logic [SIZE-1:0][DWD-1:0]              i_rdata
);

   logic [NREQ-1:0]         rreq_m;
   logic [NREQ-1:0]         wreq_m;
   logic [$clog2(NREQ)-1:0] ridx;
   logic [$clog2(NREQ)-1:0] widx;
   logic                    byp_hit;

   logic                    vld_p1;
   rf_req_idx_t             win_idx_p1;
   logic                    byp_p1;
   logic [SIZE-1:0][DWD-1:0] byp_data_p1;

   // Requests are masked during reset so no grant or RF enable can escape.
   assign rreq_m = i_rst ? '0 : i_rreq;
   assign wreq_m = i_rst ? '0 : i_wreq;

   rr_arb #(.NREQ(NREQ)) u_rd_arb (
      .clk (i_clk),
      .rst (i_rst),
      .req (rreq_m),
      .en  (~i_rst),
      .gnt (o_rgnt),
      .idx (ridx)
   );

   rr_arb #(.NREQ(NREQ)) u_wr_arb (
      .clk (i_clk),
      .rst (i_rst),
      .req (wreq_m),
      .en  (~i_rst),
      .gnt (o_wgnt),
      .idx (widx)
   );

   assign o_read  = |o_rgnt;
   assign o_write = |o_wgnt;
   assign o_raddr = o_read  ? i_raddr[ridx] : '0;
   assign o_waddr = o_write ? i_waddr[widx] : '0;
   assign o_wdata = o_write ? i_wdata[widx] : '0;

   assign byp_hit = o_read & o_write & (o_raddr == o_waddr);

   // p0 -> p1: capture the read winner and any same-address write data
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_p1      <= 1'b0;
         win_idx_p1  <= '0;
         byp_p1      <= 1'b0;
         byp_data_p1 <= '0;
      end else begin
         vld_p1 <= o_read;
         byp_p1 <= byp_hit;
         if (o_read)  win_idx_p1  <= rf_req_idx_t'(ridx);
         if (byp_hit) byp_data_p1 <= o_wdata;
      end
   end

   // p1: steer returned data to the recorded winner
   always_comb begin
      o_rvalid = '0;
      o_rdata  = '0;
      if (vld_p1) begin
         o_rvalid[win_idx_p1] = 1'b1;
         o_rdata              = byp_p1 ? byp_data_p1 : i_rdata;
      end
   end

   rd_addr_range: assert property (@(posedge i_clk) disable iff (i_rst)
      o_read |-> (int'(o_raddr) < WORDWD));
   wr_addr_range: assert property (@(posedge i_clk) disable iff (i_rst)
      o_write |-> (int'(o_waddr) < WORDWD));

endmodule
